fetch_redirect_ctrl: RTL and testbench
======================================

Name: fetch_redirect_ctrl

Overview:
- Owns the architectural fetch PC and sequences instruction-memory requests for the IF stage: one outstanding request, one-entry output slot.
- Consumes the taken/target result of the EX-stage branch unit, flushes younger stages and squashes any in-flight fetch.
- Restarts fetch at the branch target and traps on misaligned targets.
- Sits between imem and the IF/ID register.

Parameters:
- XLEN, 32, PC/address width.
- RESET_PC, 32'h0000_0000, fetch address after reset.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset; asynchronous, active-low.
- branch_taken_i  input  1  EX redirect strobe; one-cycle pulse.
- pc_branch_i  input  XLEN  redirect target; valid with branch_taken_i.
- imem_req_o  output  1  fetch request.
- imem_addr_o  output  XLEN  fetch address; equals pc_q.
- imem_gnt_i  input  1  request accepted this cycle.
- imem_rvalid_i  input  1  response data valid.
- imem_rdata_i  input  32  response instruction.
- if_valid_o  output  1  output slot holds an instruction.
- if_pc_o  output  XLEN  PC of slot instruction.
- if_instr_o  output  32  slot instruction.
- if_ready_i  input  1  IF/ID accepts the slot this cycle.
- flush_o  output  1  kill younger stages.
- misalign_o  output  1  misaligned-target trap pulse.
- misalign_pc_o  output  XLEN  offending target.
- redirect_cnt_o  output  32  statistics; see Optional Feature.
- squash_cnt_o  output  32  statistics; see Optional Feature.

Behaviour:
- Reset values:
  - pc_q = RESET_PC, state = S_REQ.
  - if_valid_o = 0, if_pc_o = 0, if_instr_o = 0.
  - misalign_o = 0, misalign_pc_o = 0, counters = 0.
  - Reset asserted mid-transaction abandons the transaction. The first rvalid after reset is not expected; imem is reset together with this block.
- States: S_REQ, S_WAIT, S_HOLD, S_DROP, S_TRAP.
- imem_req_o = (state == S_REQ). It has no combinational dependence on branch_taken_i.
- S_REQ:
  - On imem_gnt_i, go to S_WAIT.
  - Otherwise hold, with req high and address stable.
- S_WAIT, on imem_rvalid_i:
  - Slot <= {pc_q, imem_rdata_i}, if_valid_o <= 1.
  - pc_q <= pc_q + 4, wrapping modulo 2^XLEN.
  - Go to S_HOLD.
- S_HOLD:
  - On if_ready_i, clear the slot (if_valid_o <= 0) and go to S_REQ.
  - Throughput: one instruction per 3 cycles with zero-wait imem.
- Redirect (branch_taken_i = 1) has priority over all other events in the same cycle:
  - flush_o = branch_taken_i, combinational, same cycle.
  - Slot is cleared at the next edge.
  - pc_q <= pc_branch_i.
- Next state on redirect:
  - S_REQ with gnt this cycle: S_DROP.
  - S_REQ without gnt: S_REQ.
  - S_WAIT without rvalid: S_DROP.
  - S_WAIT with rvalid: data discarded, S_REQ.
  - S_HOLD: S_REQ.
  - S_DROP without rvalid: stays S_DROP; the newer target overwrites pc_q.
  - S_DROP with rvalid: S_REQ.
  - S_TRAP: S_REQ if the target is aligned.
- S_DROP: the next imem_rvalid_i is discarded (no slot write, pc_q unchanged), then go to S_REQ.
- Misaligned redirect (pc_branch_i[1:0] != 0):
  - Registered: misalign_o = 1 for exactly one cycle after the strobe; misalign_pc_o <= pc_branch_i and is held until the next misalign.
  - Next state is S_DROP if a fetch is outstanding (as above), else S_TRAP.
  - S_DROP entered on a misalign continues to S_TRAP instead of S_REQ.
  - S_TRAP: no requests. Leave only via an aligned redirect.
  - A misaligned redirect while in S_TRAP re-pulses misalign_o.
- flush_o is 0 in every cycle without branch_taken_i.

Optional Feature:
- Macro: FETCH_STATS_EN.
- Defined:
  - redirect_cnt_o increments on every branch_taken_i cycle.
  - squash_cnt_o increments on every discarded imem_rvalid_i (S_DROP, or the rvalid that coincides with a redirect).
  - Both wrap at 2^32 and reset to 0.
- Undefined: both ports are tied to 0 and no counter flops exist.

Test Plan:
- Reset release, zero-wait imem, if_ready_i = 1:
  - imem_addr_o = 0x0 with req on the first cycle.
  - if_pc_o sequence is 0x0, 0x4, 0x8, one slot every 3 cycles.
- Redirect in S_WAIT:
  - Stimulus: fetch of 0x8 granted; branch_taken_i with pc_branch_i = 0x100 before rvalid.
  - flush_o = 1 the same cycle.
  - The 0x8 response is dropped; the next request goes to 0x100 and if_pc_o = 0x100.
  - squash_cnt_o = 1 with FETCH_STATS_EN.
- Redirect coinciding with rvalid, and redirect in S_HOLD with if_ready_i = 0:
  - The slot is never presented for the old PC.
  - The next request is at the target.
- Back-to-back redirects 0x200 then 0x300 while in S_DROP:
  - One response is discarded; the next fetch is 0x300.
  - redirect_cnt_o = 2.
- Misaligned target 0x102:
  - misalign_o pulses one cycle later; misalign_pc_o = 0x102.
  - imem_req_o stays 0 until a redirect to 0x400, after which fetch resumes at 0x400.
- rst_ni asserted during S_WAIT:
  - All outputs return to reset values asynchronously.
  - After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_redirect_ctrl.sv
// Fetch PC owner and imem request sequencer with EX-branch redirect, squash and misalign trap.
// Optional statistics counters are built when FETCH_STATS_EN is defined.
module fetch_redirect_ctrl #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            branch_taken_i,
   input  logic [XLEN-1:0] pc_branch_i,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_gnt_i,
   input  logic            imem_rvalid_i,
   input  logic [31:0]     imem_rdata_i,
   output logic            if_valid_o,
   output logic [XLEN-1:0] if_pc_o,
   output logic [31:0]     if_instr_o,
   input  logic            if_ready_i,
   output logic            flush_o,
   output logic            misalign_o,
   output logic [XLEN-1:0] misalign_pc_o,
   output logic [31:0]     redirect_cnt_o,
   output logic [31:0]     squash_cnt_o
);

   typedef enum logic [2:0] {S_REQ, S_WAIT, S_HOLD, S_DROP, S_TRAP} state_t;

   state_t          r_state;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_if_pc;
   logic [31:0]     r_instr;
   logic            r_valid;
   logic            r_mis;
   logic [XLEN-1:0] r_mis_pc;
   logic            r_drop_trap;

   logic w_mis;
   logic w_outstanding;

   assign w_mis = branch_taken_i && (pc_branch_i[1:0] != 2'b00);
   // A response is still owed to us after this edge: it must be swallowed in S_DROP.
   assign w_outstanding = ((r_state == S_REQ) && imem_gnt_i) ||
                          (((r_state == S_WAIT) || (r_state == S_DROP)) && !imem_rvalid_i);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state     <= S_REQ;
         r_pc        <= RESET_PC;
         r_if_pc     <= '0;
         r_instr     <= '0;
         r_valid     <= 1'b0;
         r_mis       <= 1'b0;
         r_mis_pc    <= '0;
         r_drop_trap <= 1'b0;
      end else begin
         r_mis <= w_mis;
         if (w_mis) r_mis_pc <= pc_branch_i;
         if (branch_taken_i) begin
            r_valid <= 1'b0;
            r_pc    <= pc_branch_i;
            if (w_outstanding) begin
               r_state     <= S_DROP;
               r_drop_trap <= w_mis;
            end else begin
               r_state <= w_mis ? S_TRAP : S_REQ;
            end
         end else begin
            case (r_state)
               S_REQ:  if (imem_gnt_i) r_state <= S_WAIT;
               S_WAIT: if (imem_rvalid_i) begin
                  r_if_pc <= r_pc;
                  r_instr <= imem_rdata_i;
                  r_valid <= 1'b1;
                  r_pc    <= r_pc + XLEN'(4);
                  r_state <= S_HOLD;
               end
               S_HOLD: if (if_ready_i) begin
                  r_valid <= 1'b0;
                  r_state <= S_REQ;
               end
               S_DROP: if (imem_rvalid_i) r_state <= r_drop_trap ? S_TRAP : S_REQ;
               S_TRAP: r_state <= S_TRAP;
               default: r_state <= S_REQ;
            endcase
         end
      end
   end

   assign imem_req_o    = (r_state == S_REQ);
   assign imem_addr_o   = r_pc;
   assign if_valid_o    = r_valid;
   assign if_pc_o       = r_if_pc;
   assign if_instr_o    = r_instr;
   assign flush_o       = branch_taken_i;
   assign misalign_o    = r_mis;
   assign misalign_pc_o = r_mis_pc;

`ifdef FETCH_STATS_EN
   logic        w_discard;
   logic [31:0] r_redirect_cnt;
   logic [31:0] r_squash_cnt;

   assign w_discard = imem_rvalid_i &&
                      ((r_state == S_DROP) || ((r_state == S_WAIT) && branch_taken_i));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_redirect_cnt <= '0;
         r_squash_cnt   <= '0;
      end else begin
         if (branch_taken_i) r_redirect_cnt <= r_redirect_cnt + 32'd1;
         if (w_discard)      r_squash_cnt   <= r_squash_cnt + 32'd1;
      end
   end

   assign redirect_cnt_o = r_redirect_cnt;
   assign squash_cnt_o   = r_squash_cnt;
`else
   assign redirect_cnt_o = '0;
   assign squash_cnt_o   = '0;
`endif

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Bench for fetch_redirect_ctrl: transaction-level model checked every cycle plus directed literal checks.
module tb_fetch_redirect_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        branch_taken_i = 1'b0;
   logic [31:0] pc_branch_i = '0;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i = 1'b0;
   logic        imem_rvalid_i = 1'b0;
   logic [31:0] imem_rdata_i = '0;
   logic        if_valid_o;
   logic [31:0] if_pc_o;
   logic [31:0] if_instr_o;
   logic        if_ready_i = 1'b1;
   logic        flush_o;
   logic        misalign_o;
   logic [31:0] misalign_pc_o;
   logic [31:0] redirect_cnt_o;
   logic [31:0] squash_cnt_o;

   fetch_redirect_ctrl #(.XLEN(32), .RESET_PC(32'h0)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .branch_taken_i(branch_taken_i), .pc_branch_i(pc_branch_i),
      .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
      .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
      .if_valid_o(if_valid_o), .if_pc_o(if_pc_o), .if_instr_o(if_instr_o), .if_ready_i(if_ready_i),
      .flush_o(flush_o), .misalign_o(misalign_o), .misalign_pc_o(misalign_pc_o),
      .redirect_cnt_o(redirect_cnt_o), .squash_cnt_o(squash_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   int n_chk  = 0;
   int n_pass = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
   endtask

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
   endfunction

   // imem responder: grants when idle, answers lat cycles after the zero-wait slot
   bit          pend = 1'b0;
   int          pend_cnt = 0;
   logic [31:0] pend_addr = '0;
   logic [31:0] gnt_addr = '0;
   int          lat = 0;

   task automatic resp_step();
      if (imem_gnt_i) begin
         pend = 1'b1; pend_addr = gnt_addr; pend_cnt = lat;
      end
      imem_rvalid_i = 1'b0;
      if (pend) begin
         if (pend_cnt == 0) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = instr_of(pend_addr);
            pend = 1'b0;
         end else pend_cnt--;
      end
      imem_gnt_i = imem_req_o && !pend;
      gnt_addr   = imem_addr_o;
   endtask

   // Model: fetch tracked as transactions (owed response, must-drop flag, trap flag, slot)
   logic [31:0] m_pc, m_slot_pc, m_slot_ins, m_mis_pc, m_rcnt, m_scnt;
   bit          m_busy, m_discard, m_after_trap, m_trap, m_slot_v, m_mis;

   task automatic m_reset();
      m_pc = 32'h0; m_slot_pc = '0; m_slot_ins = '0; m_mis_pc = '0; m_rcnt = '0; m_scnt = '0;
      m_busy = 0; m_discard = 0; m_after_trap = 0; m_trap = 0; m_slot_v = 0; m_mis = 0;
   endtask

   function automatic bit m_req();
      return !m_trap && !m_busy && !m_slot_v;
   endfunction

   task automatic m_step();
      bit br, mis, req, resp;
      br   = branch_taken_i;
      mis  = br && (pc_branch_i[1:0] != 2'b00);
      req  = m_req();
      resp = imem_rvalid_i && m_busy;
      if (br) m_rcnt++;
      if (!br && m_slot_v && if_ready_i) m_slot_v = 0;
      if (resp && (m_discard || br)) m_scnt++;
      if (resp && !m_discard && !br) begin
         m_slot_v = 1; m_slot_pc = m_pc; m_slot_ins = imem_rdata_i; m_pc = m_pc + 32'd4;
      end
      if (resp) m_busy = 0;
      if (req && imem_gnt_i) m_busy = 1;
      if (br) begin
         m_slot_v = 0; m_pc = pc_branch_i;
         if (m_busy) begin m_discard = 1; m_after_trap = mis; m_trap = 0; end
         else begin m_discard = 0; m_trap = mis; end
      end else if (resp && m_discard) begin
         m_discard = 0; m_trap = m_after_trap;
      end
      m_mis = mis;
      if (mis) m_mis_pc = pc_branch_i;
   endtask

   initial begin
      m_reset();
      forever begin
         @(posedge clk_i or negedge rst_ni);
         if (!rst_ni) m_reset();
         else m_step();
      end
   end

   initial begin
      forever begin
         @(negedge clk_i);
         if (chk_en) begin
            chk("req", imem_req_o, 32'(m_req()));
            chk("addr", imem_addr_o, m_pc);
            chk("if_valid", if_valid_o, 32'(m_slot_v));
            chk("if_pc", if_pc_o, m_slot_pc);
            chk("if_instr", if_instr_o, m_slot_ins);
            chk("flush", flush_o, 32'(branch_taken_i));
            chk("misalign", misalign_o, 32'(m_mis));
            chk("misalign_pc", misalign_pc_o, m_mis_pc);
`ifdef FETCH_STATS_EN
            chk("redirect_cnt", redirect_cnt_o, m_rcnt);
            chk("squash_cnt", squash_cnt_o, m_scnt);
`else
            chk("redirect_cnt", redirect_cnt_o, 32'h0);
            chk("squash_cnt", squash_cnt_o, 32'h0);
`endif
         end
      end
   end

   task automatic tick(input logic br, input logic [31:0] tgt);
      @(posedge clk_i); #1;
      resp_step();
      branch_taken_i = br;
      pc_branch_i    = tgt;
   endtask

   task automatic wait_gnt(input string nm);
      bit seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         tick(1'b0, 32'h0);
         seen = imem_gnt_i;
      end
      if (!seen) chk({nm, "_gnt_timeout"}, 32'h0, 32'h1);
   endtask

   task automatic wait_valid(input string nm);
      bit seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         tick(1'b0, 32'h0);
         @(negedge clk_i);
         seen = if_valid_o;
      end
      if (!seen) chk({nm, "_valid_timeout"}, 32'h0, 32'h1);
   endtask

   task automatic cnt_chk(input string nm, input logic [31:0] rc, input logic [31:0] sc);
`ifdef FETCH_STATS_EN
      chk({nm, "_redirect_cnt"}, redirect_cnt_o, rc);
      chk({nm, "_squash_cnt"}, squash_cnt_o, sc);
`else
      chk({nm, "_redirect_cnt"}, redirect_cnt_o, 32'h0);
      chk({nm, "_squash_cnt"}, squash_cnt_o, 32'h0 & (rc | sc));
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got running, expected done");
      $fatal(1, "watchdog");
   end

   logic [31:0] pcs[$];
   int          cycs[$];

   initial begin
      @(posedge clk_i); #1;
      chk_en = 1'b1;
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      resp_step();
      @(negedge clk_i);
      chk("first_req", imem_req_o, 32'h1);
      chk("first_addr", imem_addr_o, 32'h0);

      // streaming, zero-wait imem, always ready
      for (int c = 1; c <= 9; c++) begin
         tick(1'b0, 32'h0);
         @(negedge clk_i);
         if (if_valid_o) begin pcs.push_back(if_pc_o); cycs.push_back(c); end
      end
      chk("stream_count", pcs.size(), 32'd3);
      if (pcs.size() == 3) begin
         chk("stream_pc0", pcs[0], 32'h0);
         chk("stream_pc1", pcs[1], 32'h4);
         chk("stream_pc2", pcs[2], 32'h8);
         chk("stream_gap01", cycs[1] - cycs[0], 32'd3);
         chk("stream_gap12", cycs[2] - cycs[1], 32'd3);
      end

      // redirect while waiting on a response
      lat = 2;
      wait_gnt("s_wait");
      tick(1'b1, 32'h100);
      @(negedge clk_i);
      chk("s_wait_flush", flush_o, 32'h1);
      lat = 0;
      wait_valid("s_wait");
      chk("s_wait_pc", if_pc_o, 32'h100);
      chk("s_wait_instr", if_instr_o, instr_of(32'h100));
      cnt_chk("s_wait", 32'd1, 32'd1);

      // redirect coinciding with rvalid
      wait_gnt("coincide");
      tick(1'b1, 32'h180);
      wait_valid("coincide");
      chk("coincide_pc", if_pc_o, 32'h180);

      // redirect while the slot is stalled
      if_ready_i = 1'b0;
      wait_valid("hold");
      tick(1'b1, 32'h1C0);
      @(negedge clk_i);
      if_ready_i = 1'b1;
      wait_valid("hold");
      chk("hold_pc", if_pc_o, 32'h1C0);

      // back-to-back redirects while dropping
      lat = 3;
      wait_gnt("b2b");
      tick(1'b1, 32'h200);
      tick(1'b1, 32'h300);
      lat = 0;
      wait_valid("b2b");
      chk("b2b_pc", if_pc_o, 32'h300);
      cnt_chk("b2b", 32'd5, 32'd3);

      // misaligned target with nothing in flight
      if_ready_i = 1'b0;
      wait_valid("mis");
      tick(1'b1, 32'h102);
      tick(1'b0, 32'h0);
      @(negedge clk_i);
      if_ready_i = 1'b1;
      chk("mis_pulse", misalign_o, 32'h1);
      chk("mis_pc", misalign_pc_o, 32'h102);
      tick(1'b0, 32'h0);
      @(negedge clk_i);
      chk("mis_pulse_end", misalign_o, 32'h0);
      for (int i = 0; i < 4; i++) begin
         tick(1'b0, 32'h0);
         @(negedge clk_i);
         chk("trap_no_req", imem_req_o, 32'h0);
      end
      tick(1'b1, 32'h400);
      wait_valid("trap_exit");
      chk("trap_exit_pc", if_pc_o, 32'h400);

      // misaligned with a fetch outstanding: drop, then trap; re-pulse inside trap
      lat = 2;
      wait_gnt("mis_drop");
      tick(1'b1, 32'h206);
      for (int i = 0; i < 5; i++) tick(1'b0, 32'h0);
      @(negedge clk_i);
      chk("mis_drop_trap", imem_req_o, 32'h0);
      tick(1'b1, 32'h30A);
      tick(1'b0, 32'h0);
      @(negedge clk_i);
      chk("retrap_pulse", misalign_o, 32'h1);
      chk("retrap_pc", misalign_pc_o, 32'h30A);
      lat = 0;
      tick(1'b1, 32'h500);
      wait_valid("retrap_exit");
      chk("retrap_exit_pc", if_pc_o, 32'h500);

      // asynchronous reset in the middle of a fetch
      lat = 3;
      wait_gnt("rst");
      tick(1'b0, 32'h0);
      #2;
      rst_ni = 1'b0;
      imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; pend = 1'b0;
      #1;
      chk("rst_req", imem_req_o, 32'h1);
      chk("rst_addr", imem_addr_o, 32'h0);
      chk("rst_valid", if_valid_o, 32'h0);
      chk("rst_if_pc", if_pc_o, 32'h0);
      chk("rst_instr", if_instr_o, 32'h0);
      chk("rst_mis", misalign_o, 32'h0);
      chk("rst_mis_pc", misalign_pc_o, 32'h0);
      chk("rst_redirect_cnt", redirect_cnt_o, 32'h0);
      chk("rst_squash_cnt", squash_cnt_o, 32'h0);
      lat = 0;
      repeat (2) @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      resp_step();
      wait_valid("restart0");
      chk("restart_pc0", if_pc_o, 32'h0);
      wait_valid("restart1");
      chk("restart_pc1", if_pc_o, 32'h4);

      repeat (3) tick(1'b0, 32'h0);
      @(negedge clk_i);
      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
